// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types and constants for the writeback port arbiter
package wb_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } wb_state_e;

    localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/md_scoreboard.sv
// rtl/md_scoreboard.sv - single-entry MUL/DIV destination scoreboard with RAW/WAW hazard detect
module md_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_issue,
    input  logic [RA_W-1:0] md_issue_rd,
    input  logic            clr_valid,
    input  logic [RA_W-1:0] clr_rd,
    input  logic [RA_W-1:0] core_rs1,
    input  logic [RA_W-1:0] core_rs2,
    input  logic [RA_W-1:0] core_wb_rd,
    output logic            hazard,
    output logic            issue_block
);

    localparam logic [RA_W-1:0] X0 = RA_W'(REG_X0);

    logic            pend_valid;
    logic [RA_W-1:0] pend_rd;
    logic            clear;

    assign clear       = pend_valid && clr_valid && (clr_rd == pend_rd);
    // A second issue is only refused if the outstanding result is not retiring this cycle.
    assign issue_block = pend_valid && !clear;
    assign hazard      = pend_valid && (pend_rd != X0) &&
                         ((pend_rd == core_rs1) || (pend_rd == core_rs2) || (pend_rd == core_wb_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_rd    <= '0;
        end else if (md_issue && !issue_block) begin
            pend_valid <= 1'b1;
            pend_rd    <= md_issue_rd;
        end else if (clear) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between core and MUL/DIV unit
// Optional starvation guard (wait counter, FORCE drain) enabled by WB_STARVE_GUARD_EN.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int RA_W         = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             core_wb_valid,
    input  logic [RA_W-1:0]  core_wb_rd,
    input  logic [WIDTH-1:0] core_wb_data,
    input  logic [RA_W-1:0]  core_rs1,
    input  logic [RA_W-1:0]  core_rs2,
    input  logic             md_issue,
    input  logic [RA_W-1:0]  md_issue_rd,
    input  logic             md_valid,
    input  logic [RA_W-1:0]  md_rd,
    input  logic [WIDTH-1:0] md_data,
    output logic             md_ready,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             core_stall
);

    localparam logic [RA_W-1:0] X0 = RA_W'(REG_X0);

    wb_state_e        state;
    logic             hold_valid;
    logic [RA_W-1:0]  hold_rd;
    logic [WIDTH-1:0] hold_data;

`ifdef WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    logic hazard, issue_block;
    logic transfer, md_to_x0, core_busy;
    logic bypass, drain, discard;
    logic clr_valid;
    logic [RA_W-1:0] clr_rd;

    assign md_ready  = !hold_valid;
    assign transfer  = md_valid && md_ready;
    assign md_to_x0  = (md_rd == X0);
    // A hazard-stalled core has its write dropped, so it does not occupy the port.
    assign core_busy = core_wb_valid && (core_wb_rd != X0) && !hazard;
    assign bypass    = transfer && !md_to_x0 && !core_busy;
    assign discard   = transfer && md_to_x0;
    assign drain     = ((state == ST_HELD) && !core_busy) || (state == ST_FORCE);

    assign clr_valid  = drain || bypass || discard;
    assign clr_rd     = drain ? hold_rd : md_rd;
    assign core_stall = hazard || (md_issue && issue_block) || (state == ST_FORCE);

    md_scoreboard #(.RA_W(RA_W)) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .clr_valid   (clr_valid),
        .clr_rd      (clr_rd),
        .core_rs1    (core_rs1),
        .core_rs2    (core_rs2),
        .core_wb_rd  (core_wb_rd),
        .hazard      (hazard),
        .issue_block (issue_block)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (drain) begin
            rf_we    = 1'b1;
            rf_waddr = hold_rd;
            rf_wdata = hold_data;
        end else if (bypass) begin
            rf_we    = 1'b1;
            rf_waddr = md_rd;
            rf_wdata = md_data;
        end else if (core_wb_valid && !core_stall && (core_wb_rd != X0)) begin
            rf_we    = 1'b1;
            rf_waddr = core_wb_rd;
            rf_wdata = core_wb_data;
        end
        if (!rst_n) begin
            rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
`ifdef WB_STARVE_GUARD_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transfer && !md_to_x0 && core_busy) begin
                        state      <= ST_HELD;
                        hold_valid <= 1'b1;
                        hold_rd    <= md_rd;
                        hold_data  <= md_data;
`ifdef WB_STARVE_GUARD_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                ST_HELD: begin
                    if (drain) begin
                        state      <= ST_IDLE;
                        hold_valid <= 1'b0;
                    end else begin
`ifdef WB_STARVE_GUARD_EN
                        if (wait_cnt != CNT_W'(STARVE_LIMIT)) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (int'(wait_cnt) >= STARVE_LIMIT - 1) begin
                            state <= ST_FORCE;
                        end
`endif
                    end
                end
                ST_FORCE: begin
                    state      <= ST_IDLE;
                    hold_valid <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    hold_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int WIDTH        = 32;
    localparam int RA_W         = 5;
    localparam int STARVE_LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             core_wb_valid;
    logic [RA_W-1:0]  core_wb_rd;
    logic [WIDTH-1:0] core_wb_data;
    logic [RA_W-1:0]  core_rs1, core_rs2;
    logic             md_issue;
    logic [RA_W-1:0]  md_issue_rd;
    logic             md_valid;
    logic [RA_W-1:0]  md_rd;
    logic [WIDTH-1:0] md_data;
    logic             md_ready;
    logic             rf_we;
    logic [RA_W-1:0]  rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             core_stall;

    int checks   = 0;
    int failures = 0;

    wb_port_arbiter #(.WIDTH(WIDTH), .RA_W(RA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_wb_valid (core_wb_valid),
        .core_wb_rd    (core_wb_rd),
        .core_wb_data  (core_wb_data),
        .core_rs1      (core_rs1),
        .core_rs2      (core_rs2),
        .md_issue      (md_issue),
        .md_issue_rd   (md_issue_rd),
        .md_valid      (md_valid),
        .md_rd         (md_rd),
        .md_data       (md_data),
        .md_ready      (md_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .core_stall    (core_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [RA_W-1:0]  rd;
        logic [WIDTH-1:0] data;
    } res_t;

    // Model: results parked because the core owns the port, plus the outstanding-op record.
    res_t            held_q[$];
    int              waited;
    bit              forcing;
    bit              pend;
    logic [RA_W-1:0] pend_rd;

    always @(negedge clk) begin : compare
        bit               hz, claims, ret, wr, clr, st, ewe;
        logic [RA_W-1:0]  rrd, ea;
        logic [WIDTH-1:0] rdat, ed;
        if (!rst_n) begin
            held_q.delete();
            waited  = 0;
            forcing = 0;
            pend    = 0;
            pend_rd = '0;
            chk("m_rst_we", rf_we, 0);
            chk("m_rst_ready", md_ready, 1);
            chk("m_rst_stall", core_stall, 0);
        end else begin
            hz = pend && pend_rd != 0 &&
                 (pend_rd == core_rs1 || pend_rd == core_rs2 || pend_rd == core_wb_rd);
            claims = core_wb_valid && core_wb_rd != 0 && !hz;
            ret  = 0;
            wr   = 0;
            rrd  = md_rd;
            rdat = md_data;
            if (held_q.size() != 0) begin
                rrd  = held_q[0].rd;
                rdat = held_q[0].data;
                if (forcing || !claims) begin
                    ret = 1;
                    wr  = 1;
                end
            end else if (md_valid) begin
                if (md_rd == 0) ret = 1;
                else if (!claims) begin
                    ret = 1;
                    wr  = 1;
                end
            end
            clr = pend && ret && rrd == pend_rd;
            st  = hz || forcing || (md_issue && pend && !clr);
            ewe = wr;
            ea  = rrd;
            ed  = rdat;
            if (!wr && core_wb_valid && !st && core_wb_rd != 0) begin
                ewe = 1;
                ea  = core_wb_rd;
                ed  = core_wb_data;
            end
            chk("m_ready", md_ready, (held_q.size() == 0) ? 1 : 0);
            chk("m_stall", core_stall, st);
            chk("m_we", rf_we, ewe);
            if (ewe) begin
                chk("m_waddr", rf_waddr, ea);
                chk("m_wdata", rf_wdata, ed);
            end
            if (held_q.size() != 0) begin
                if (ret) begin
                    void'(held_q.pop_front());
                    forcing = 0;
                end else begin
                    waited++;
`ifdef WB_STARVE_GUARD_EN
                    if (waited >= STARVE_LIMIT) forcing = 1;
`endif
                end
            end else if (md_valid && !ret) begin
                held_q.push_back('{md_rd, md_data});
                waited = 0;
            end
            if (md_issue && !(pend && !clr)) begin
                pend    = 1;
                pend_rd = md_issue_rd;
            end else if (clr) begin
                pend = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        core_wb_valid = 0; core_wb_rd = '0; core_wb_data = '0;
        core_rs1 = '0; core_rs2 = '0;
        md_issue = 0; md_issue_rd = '0;
        md_valid = 0; md_rd = '0; md_data = '0;
    endtask

    task automatic core_write(input logic [RA_W-1:0] rd, input logic [WIDTH-1:0] d);
        core_wb_valid = 1; core_wb_rd = rd; core_wb_data = d;
    endtask

    task automatic md_result(input logic [RA_W-1:0] rd, input logic [WIDTH-1:0] d);
        md_valid = 1; md_rd = rd; md_data = d;
    endtask

    task automatic issue(input logic [RA_W-1:0] rd);
        md_issue = 1; md_issue_rd = rd;
    endtask

    initial begin
        rst_n = 0;
        core_wb_valid = 0; core_wb_rd = '0; core_wb_data = '0;
        core_rs1 = '0; core_rs2 = '0;
        md_issue = 0; md_issue_rd = '0;
        md_valid = 0; md_rd = '0; md_data = '0;
        #2;
        chk("reset_we", rf_we, 0);
        chk("reset_ready", md_ready, 1);
        chk("reset_stall", core_stall, 0);
        next_cycle();
        next_cycle();
        rst_n = 1;

        // Idle core: MUL/DIV result goes straight through.
        next_cycle();
        md_result(5, 32'h0000_0007);
        #3;
        chk("bypass_we", rf_we, 1);
        chk("bypass_waddr", rf_waddr, 5);
        chk("bypass_wdata", rf_wdata, 7);
        next_cycle();
        #3 chk("bypass_ready_after", md_ready, 1);

        // Busy core: result to x3 is parked.
        next_cycle();
        core_write(1, 32'haa); md_result(3, 32'h33);
        #3 chk("held_core_waddr", rf_waddr, 1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            core_write(1, 32'haa);
            #3;
            chk("held_ready", md_ready, 0);
            chk("held_core_wins", rf_waddr, 1);
        end
        next_cycle();
        core_write(1, 32'haa);
        #3;
`ifdef WB_STARVE_GUARD_EN
        chk("force_stall", core_stall, 1);
        chk("force_waddr", rf_waddr, 3);
        chk("force_wdata", rf_wdata, 32'h33);
`else
        chk("noguard_stall", core_stall, 0);
        chk("noguard_ready", md_ready, 0);
        chk("noguard_waddr", rf_waddr, 1);
`endif
        next_cycle();
        #3;
`ifdef WB_STARVE_GUARD_EN
        chk("after_force_we", rf_we, 0);
        chk("after_force_ready", md_ready, 1);
`else
        chk("noguard_drain_we", rf_we, 1);
        chk("noguard_drain_waddr", rf_waddr, 3);
`endif
        next_cycle();
        #3 chk("drained_ready", md_ready, 1);

        // RAW on x8 stalls until its result lands.
        next_cycle();
        issue(8);
        #3 chk("raw_issue_stall", core_stall, 0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            core_rs1 = 8;
            #3 chk("raw_stall", core_stall, 1);
        end
        next_cycle();
        core_rs1 = 8; md_result(8, 32'h88);
        #3;
        chk("raw_write_stall", core_stall, 1);
        chk("raw_write_waddr", rf_waddr, 8);
        next_cycle();
        core_rs1 = 8;
        #3 chk("raw_released", core_stall, 0);

        // x0 result and x0 core write both dropped; scoreboard clears.
        next_cycle();
        issue(0);
        next_cycle();
        md_result(0, 32'h1234); core_write(0, 32'h55);
        #3;
        chk("x0_we", rf_we, 0);
        chk("x0_ready", md_ready, 1);
        next_cycle();
        issue(4);
        #3;
        chk("x0_cleared_stall", core_stall, 0);
        chk("x0_ready_after", md_ready, 1);
        next_cycle();
        md_result(4, 32'h44);
        #3 chk("x4_waddr", rf_waddr, 4);

        // Second issue while one is outstanding stalls.
        next_cycle();
        issue(10);
        next_cycle();
        issue(11);
        #3 chk("second_issue_stall", core_stall, 1);
        next_cycle();
        md_result(10, 32'h10);
        next_cycle();
        issue(11);
        #3 chk("reissue_ok", core_stall, 0);
        next_cycle();
        md_result(11, 32'h11);

        // New issue overlapping the retiring write takes the scoreboard.
        next_cycle();
        issue(6);
        next_cycle();
        md_result(6, 32'h66); issue(7);
        #3;
        chk("overlap_stall", core_stall, 0);
        chk("overlap_waddr", rf_waddr, 6);
        next_cycle();
        core_rs1 = 7;
        #3 chk("overlap_new_pend", core_stall, 1);
        next_cycle();
        md_result(7, 32'h77);
        next_cycle();
        core_rs2 = 7;
        #3 chk("overlap_released", core_stall, 0);

        // Reset while x9 is parked.
        next_cycle();
        core_write(1, 32'hbb); md_result(9, 32'h99);
        next_cycle();
        core_write(1, 32'hbb);
        #1 chk("rst_pre_ready", md_ready, 0);
        #1 rst_n = 0;
        #1;
        chk("async_we", rf_we, 0);
        chk("async_ready", md_ready, 1);
        chk("async_stall", core_stall, 0);
        next_cycle();
        next_cycle();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #3;
            chk("post_rst_we", rf_we, 0);
            chk("post_rst_ready", md_ready, 1);
        end
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
